rr_arb4_lock: RTL and testbench
===============================

// Module: rr_arb4_lock
// PURPOSE
//  4-requester round-robin arbiter with grant locking and a hold timeout.
//  Produces a registered one-hot grant gnt[3:0] plus enable gnt_en.
//  These drive the i/en inputs of the downstream 4:2 encoder stage, which
//  returns the winning index to the shared-resource mux.
//  gnt is always exactly one-hot or all-zero, so the encoder never sees an
//  illegal code.
// PARAMETERS
//  MAX_HOLD  8  max consecutive cycles one requester may hold the grant (legal 2..256)
//  CNT_W     $clog2(MAX_HOLD)  localparam, hold-counter width
// PORTS
//  clk      in   1  single clock, all state updates on posedge
//  rst      in   1  synchronous, active-high reset
//  req      in   4  request lines, level-sensitive, bit n = requester n
//  done     in   1  holder ends its transaction; sampled only in GRANT
//  gnt      out  4  registered one-hot grant; 4'b0000 when idle
//  gnt_en   out  1  registered; equals |gnt; drives encoder en
//  timeout  out  1  registered 1-cycle pulse after a forced release
// BEHAVIOUR
//  - Reset (rst=1 at posedge)
//    - state=IDLE, gnt=0, gnt_en=0, timeout=0, hold_cnt=0.
//    - ptr=0, so requester 0 has top priority.
//    - Applies from any state, including mid-grant.
//    - First arbitration happens at the first posedge with rst=0.
//  - States: IDLE, GRANT. Outputs are registered and never decoded combinationally.
//  - IDLE
//    - gnt=0, gnt_en=0.
//    - If req!=0 at a posedge: winner = first set bit searching ptr, ptr+1,
//      ... mod 4. Load gnt=onehot(winner), gnt_en=1, hold_cnt=0, go to GRANT.
//    - Latency: req sampled at edge k, so gnt is valid after edge k.
//    - If req==0, stay in IDLE.
//  - GRANT (holder w)
//    - gnt is held stable. hold_cnt increments by 1 per cycle.
//    - Release when any of the following hold at a posedge:
//      (a) done=1
//      (b) req[w]=0 (requester dropped)
//      (c) hold_cnt==MAX_HOLD-1 (forced)
//    - On release: gnt=0, gnt_en=0, ptr=(w+1) mod 4, go to IDLE.
//    - A grant therefore lasts at most MAX_HOLD cycles.
//    - IDLE always lasts at least 1 cycle, so there is a 1-cycle all-zero gap
//      between consecutive grants.
//  - timeout
//    - Set to 1 for exactly one cycle (the first IDLE cycle) only when the
//      release cause was (c) alone.
//    - If (a) or (b) coincides with (c), there is no pulse.
//    - timeout=0 in every other cycle.
//  - Requests arriving during GRANT are not acted on until the next IDLE.
//    There is no preemption.
//  - Invariants: $onehot0(gnt) always; gnt_en==|gnt always; gnt changes only
//    on IDLE<->GRANT transitions.
//  - ptr wraps 3->0. hold_cnt saturates logically via release and never wraps
//    in GRANT.
// TESTING
//  1. rst, then req=0101 held; pulse done 2 cycles into each grant.
//     -> gnt 0001, then 0000 for 1 cycle, then 0100, then 0000, then 0001.
//  2. req=1111 constant, done pulsed in each grant's first cycle.
//     -> gnt 0001,0000,0010,0000,0100,0000,1000,0000,0001; timeout=0 throughout.
//  3. MAX_HOLD=8, req=0010 held, done=0.
//     -> gnt=0010 for exactly 8 cycles, then 0000 with timeout=1 for 1 cycle,
//        then 0010 again.
//  4. MAX_HOLD=8, done=1 in the 8th grant cycle.
//     -> release as in 3, but timeout stays 0.
//  5. req=0100 granted, then req drops to 0000 on grant cycle 3.
//     -> gnt=0000 after that edge, gnt_en=0, timeout=0, state stays IDLE.
//  6. Grant held on 1000, assert rst for 1 cycle, then req=1001.
//     -> gnt=0000 right after the rst edge; the next grant is 0001 (ptr reset
//        to 0). Check the $onehot0(gnt) and gnt_en==|gnt assertions in every test.

Source files
------------

// File: rtl/rr_arb4_lock.sv
// rr_arb4_lock: 4-requester round-robin arbiter with grant locking and a hold
// timeout. Produces a registered one-hot grant and its enable for the
// downstream 4:2 encoder stage. A 1-cycle timeout pulse follows a forced
// release.
//
// Handshake: req is level-sensitive. A requester keeps req[n] high for as long
// as it wants the resource. It ends its transaction either by pulsing done
// while it holds the grant or by dropping req[n]. If it reaches MAX_HOLD
// consecutive grant cycles, the arbiter takes the grant back.
module rr_arb4_lock #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_en,
  output logic       timeout,
  output logic       dbg_state
);

  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_win;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_gnt;
  logic             r_gnt_en;
  logic             r_timeout;

  logic [7:0]       w_dbl;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_win;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_max;
  logic             w_release;

  // Rotate requests so that bit 0 is the current top-priority requester.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[{1'b0, r_ptr} +: 4];

  // Lowest set bit of the rotated vector is the offset from ptr to the winner.
  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  assign w_win = r_ptr + w_off;

  // Release causes for the current holder. Only the forced cause on its own
  // produces a timeout pulse.
  assign w_rel_done = done;
  assign w_rel_drop = ~req[r_win];
  assign w_rel_max  = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release  = w_rel_done | w_rel_drop | w_rel_max;

  // Arbitration FSM. All outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_win      <= 2'd0;
      r_hold_cnt <= '0;
      r_gnt      <= 4'b0000;
      r_gnt_en   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            r_win      <= w_win;
            r_gnt      <= 4'b0001 << w_win;
            r_gnt_en   <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_gnt     <= 4'b0000;
            r_gnt_en  <= 1'b0;
            r_ptr     <= r_win + 2'd1;
            r_timeout <= w_rel_max & ~w_rel_done & ~w_rel_drop;
            r_state   <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_gnt    <= 4'b0000;
          r_gnt_en <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_en    = r_gnt_en;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arb4_lock.sv
// tb_rr_arb4_lock: directed vectors with hand-computed grants for rr_arb4_lock
// (MAX_HOLD = 8).
module tb_rr_arb4_lock;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_en;
  logic       timeout;
  logic       dbg_state;

  int n_tests;
  int n_fail;

  rr_arb4_lock #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_en    (gnt_en),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check the output invariants away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
    check("inv_gnt_en", {7'd0, gnt_en}, {7'd0, |gnt});
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    check("rst_gnt", {4'd0, gnt}, 8'h00);
    check("rst_timeout", {7'd0, timeout}, 8'h00);
    check("rst_state", {7'd0, dbg_state}, 8'h00);
    rst = 1'b0;
  endtask

  logic [3:0] exp2 [9];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();

    // Test 1: req=0101, done pulsed in the second grant cycle
    do_reset();
    req = 4'b0101;
    tick(); check("t1_g0_c1", {4'd0, gnt}, 8'h01);
    tick(); check("t1_g0_c2", {4'd0, gnt}, 8'h01);
    done = 1'b1;
    tick(); check("t1_gap0", {4'd0, gnt}, 8'h00);
    done = 1'b0;
    tick(); check("t1_g2_c1", {4'd0, gnt}, 8'h04);
    tick(); check("t1_g2_c2", {4'd0, gnt}, 8'h04);
    done = 1'b1;
    tick(); check("t1_gap1", {4'd0, gnt}, 8'h00);
    done = 1'b0;
    tick(); check("t1_g0_again", {4'd0, gnt}, 8'h01);

    // Test 2: req=1111, done pulsed in each grant's first cycle
    do_reset();
    exp2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
             4'b0000, 4'b1000, 4'b0000, 4'b0001};
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("t2_gnt%0d", i), {4'd0, gnt}, {4'd0, exp2[i]});
      check($sformatf("t2_to%0d", i), {7'd0, timeout}, 8'h00);
      done = (exp2[i] != 4'b0000);
    end
    done = 1'b0;

    // Test 3: req=0010 held, forced release after 8 cycles
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("t3_hold%0d", i), {4'd0, gnt}, 8'h02);
      check($sformatf("t3_to%0d", i), {7'd0, timeout}, 8'h00);
    end
    tick();
    check("t3_rel_gnt", {4'd0, gnt}, 8'h00);
    check("t3_rel_to", {7'd0, timeout}, 8'h01);
    check("t3_rel_state", {7'd0, dbg_state}, 8'h00);
    tick();
    check("t3_regrant", {4'd0, gnt}, 8'h02);
    check("t3_to_clear", {7'd0, timeout}, 8'h00);

    // Test 4: done coincides with the forced release, no pulse
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 8; i++) tick();
    check("t4_c8_gnt", {4'd0, gnt}, 8'h02);
    done = 1'b1;
    tick();
    check("t4_rel_gnt", {4'd0, gnt}, 8'h00);
    check("t4_rel_to", {7'd0, timeout}, 8'h00);
    done = 1'b0;

    // Test 5: requester drops on grant cycle 3
    do_reset();
    req = 4'b0100;
    tick(); check("t5_c1", {4'd0, gnt}, 8'h04);
    tick(); tick();
    check("t5_c3", {4'd0, gnt}, 8'h04);
    req = 4'b0000;
    tick();
    check("t5_drop_gnt", {4'd0, gnt}, 8'h00);
    check("t5_drop_en", {7'd0, gnt_en}, 8'h00);
    check("t5_drop_to", {7'd0, timeout}, 8'h00);
    tick();
    check("t5_idle_state", {7'd0, dbg_state}, 8'h00);
    check("t5_idle_gnt", {4'd0, gnt}, 8'h00);

    // Test 6: reset mid-grant restores ptr to 0
    do_reset();
    req = 4'b1000;
    tick(); check("t6_g3", {4'd0, gnt}, 8'h08);
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_gnt", {4'd0, gnt}, 8'h00);
    check("t6_rst_en", {7'd0, gnt_en}, 8'h00);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    check("t6_after_rst", {4'd0, gnt}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
